ets_sweep_ctrl: RTL and testbench
=================================

# ets_sweep_ctrl

Phase-sweep sequencer for the equivalent-time-sampling (ETS) acquisition path.
- Steps a delay-line phase select through taps 0..last_tap.
- At each tap, waits a settle interval, then runs one accumulation on the downstream ETS accumulator over a start/done handshake.
- Captures the 32-bit hit count and streams it out as a {tap, count} beat on a valid/ready interface towards the readout DMA/FIFO.

## Interface
Parameters:
- TAP_W, 8, width of phase index (up to 2^TAP_W taps)
- SETTLE, 16, clk cycles between phase_load and acc_start rising (legal 1..65535)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- sweep_start  in  1  single-cycle pulse; honoured only in IDLE
- abort  in  1  single-cycle pulse; terminates sweep (see Operation)
- last_tap  in  TAP_W  final tap index; sampled on accepted sweep_start
- phase_sel  out  TAP_W  current tap to delay line
- phase_load  out  1  one-cycle strobe, phase_sel changed
- acc_start  out  1  level request to accumulator
- acc_done  in  1  accumulator result valid; held while acc_start high
- acc_data  in  32  accumulator count; valid while acc_done high
- m_valid  out  1  result beat valid
- m_ready  in  1  sink ready
- m_tap  out  TAP_W  tap index of beat
- m_count  out  32  captured count
- m_last  out  1  beat is final tap of sweep
- busy  out  1  high from accepted sweep_start until FINISH/abort completes
- sweep_done  out  1  one-cycle pulse, sweep completed normally

## Operation
States: IDLE, SETTLE, ACQ, EMIT, FINISH, DRAIN.
- IDLE: outputs quiescent. On sweep_start: latch last_tap, tap=0, phase_sel=0, phase_load=1, settle counter=SETTLE, go to SETTLE.
- SETTLE: decrement the counter each cycle. At zero, go to ACQ with acc_start=1.
- ACQ: hold acc_start=1. On the first cycle acc_done=1, register m_count=acc_data and m_tap=tap, set m_last=(tap==last_tap), then go to EMIT.
- EMIT:
  - acc_start=0 and m_valid=1.
  - Leave only when the beat is accepted (m_valid&&m_ready) AND acc_done has been sampled low at least once since leaving ACQ. The acc_done-low condition guarantees the accumulator has left its done state and cleared.
  - If tap==last_tap, go to FINISH.
  - Otherwise tap+=1, phase_sel updated, phase_load=1, reload the settle counter, go to SETTLE.
- FINISH: sweep_done=1 for one cycle, busy=0, go to IDLE.
- Abort:
  - In SETTLE or ACQ: drop acc_start, go to DRAIN.
  - In EMIT: held pending, taken after the current beat is accepted. m_valid is never withdrawn.
  - DRAIN waits until acc_done=0, then goes to IDLE. No sweep_done is issued. busy falls on entry to IDLE.
- Abort in IDLE/FINISH: ignored.
- sweep_start outside IDLE: ignored.
- m_tap, m_count, m_last: stable while m_valid=1.
- Tap arithmetic: tap never wraps. last_tap=2^TAP_W-1 is legal and yields 2^TAP_W beats.

## Timing
- Reset values: phase_sel=0, phase_load=0, acc_start=0, m_valid=0, m_tap=0, m_count=0, m_last=0, busy=0, sweep_done=0; state IDLE.
- Reset mid-operation: all outputs return to reset values asynchronously. No further beats.
- sweep_start sampled at edge t: busy=1, phase_load=1, phase_sel=0 during cycle t+1.
- acc_start rises in cycle t+1+SETTLE.
- acc_done first high at edge e: m_valid=1 and acc_start=0 from cycle e+1.
- Beat accepted at edge a, with acc_done already seen low:
  - next tap: phase_load in cycle a+1.
  - last tap: sweep_done in cycle a+1, busy=0 from cycle a+2.
- acc_start low gap between taps is at least SETTLE+1 cycles, which covers the accumulator's clear cycle.
- All outputs registered.

## Test plan
- last_tap=3, SETTLE=4, accumulator model returns 100+tap, m_ready=1 → 4 beats (0,100)..(3,103); m_last only on tap 3; one sweep_done; acc_start rises exactly 4 cycles after each phase_load.
- Same sweep, m_ready toggling 1-of-3 cycles → identical beats; payload stable while stalled; no phase_load before acceptance.
- acc_done held high 5 cycles after acc_start falls, m_ready=1 → EMIT holds until acc_done low; no early phase_load.
- abort in SETTLE of tap 2 → acc_start stays 0; no beat for tap 2; busy low after DRAIN; no sweep_done. A new sweep_start then runs normally from tap 0.
- abort in EMIT with m_ready=0 for 10 cycles → beat persists; after acceptance, return to IDLE; no sweep_done.
- rst_n asserted during ACQ on tap 1 → all outputs 0 immediately; sweep_start after release restarts at tap 0.

Source files
------------

// File: rtl/ets_sweep_ctrl.sv
// Phase-sweep sequencer for the ETS acquisition path: walks the delay-line
// tap from 0 to last_tap, lets each tap settle, runs one accumulation and
// streams the {tap, count} result out on a valid/ready port.
module ets_sweep_ctrl #(
  parameter int TAP_W  = 8,
  parameter int SETTLE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sweep_start,
  input  logic             abort,
  input  logic [TAP_W-1:0] last_tap,
  output logic [TAP_W-1:0] phase_sel,
  output logic             phase_load,
  output logic             acc_start,
  input  logic             acc_done,
  input  logic [31:0]      acc_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [TAP_W-1:0] m_tap,
  output logic [31:0]      m_count,
  output logic             m_last,
  output logic             busy,
  output logic             sweep_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ACQ,
    S_EMIT,
    S_FINISH,
    S_DRAIN
  } state_t;

  localparam logic [15:0]      SETTLE_LD = 16'(SETTLE);
  localparam logic [TAP_W-1:0] TAP_ONE   = {{(TAP_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [TAP_W-1:0] last, last_nxt;
  logic [15:0]      cnt, cnt_nxt;
  // low_seen: acc_done observed low since the result was captured
  // taken: the current beat has already been handed to the sink
  // abort_pend: abort arrived while a beat was outstanding
  logic             low_seen, low_seen_nxt;
  logic             taken, taken_nxt;
  logic             abort_pend, abort_pend_nxt;

  logic [TAP_W-1:0] phase_sel_nxt, m_tap_nxt;
  logic [31:0]      m_count_nxt;
  logic             phase_load_nxt, acc_start_nxt, m_valid_nxt;
  logic             m_last_nxt, busy_nxt, sweep_done_nxt;

  // EMIT exit qualifiers, including what is sampled on the current edge
  logic             seen_now, taken_now, pend_now;

  assign seen_now  = low_seen | ~acc_done;
  assign taken_now = taken | (m_valid & m_ready);
  assign pend_now  = abort_pend | abort;

  // State and every output are registered; reset returns all to quiescent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last       <= '0;
      cnt        <= '0;
      low_seen   <= 1'b0;
      taken      <= 1'b0;
      abort_pend <= 1'b0;
      phase_sel  <= '0;
      phase_load <= 1'b0;
      acc_start  <= 1'b0;
      m_valid    <= 1'b0;
      m_tap      <= '0;
      m_count    <= '0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      cnt        <= cnt_nxt;
      low_seen   <= low_seen_nxt;
      taken      <= taken_nxt;
      abort_pend <= abort_pend_nxt;
      phase_sel  <= phase_sel_nxt;
      phase_load <= phase_load_nxt;
      acc_start  <= acc_start_nxt;
      m_valid    <= m_valid_nxt;
      m_tap      <= m_tap_nxt;
      m_count    <= m_count_nxt;
      m_last     <= m_last_nxt;
      busy       <= busy_nxt;
      sweep_done <= sweep_done_nxt;
    end
  end

  // Next-state and next-output decode; strobes default low, the rest hold.
  always_comb begin
    state_nxt      = state;
    last_nxt       = last;
    cnt_nxt        = cnt;
    low_seen_nxt   = low_seen;
    taken_nxt      = taken;
    abort_pend_nxt = abort_pend;
    phase_sel_nxt  = phase_sel;
    phase_load_nxt = 1'b0;
    acc_start_nxt  = acc_start;
    m_valid_nxt    = m_valid;
    m_tap_nxt      = m_tap;
    m_count_nxt    = m_count;
    m_last_nxt     = m_last;
    busy_nxt       = busy;
    sweep_done_nxt = 1'b0;

    unique case (state)
      S_IDLE: begin
        acc_start_nxt = 1'b0;
        m_valid_nxt   = 1'b0;
        busy_nxt      = 1'b0;
        if (sweep_start) begin
          last_nxt       = last_tap;
          phase_sel_nxt  = '0;
          phase_load_nxt = 1'b1;
          cnt_nxt        = SETTLE_LD;
          busy_nxt       = 1'b1;
          abort_pend_nxt = 1'b0;
          state_nxt      = S_SETTLE;
        end
      end

      // cnt==1 on the last settle edge so acc_start appears SETTLE cycles
      // after phase_load.
      S_SETTLE: begin
        if (abort) begin
          acc_start_nxt = 1'b0;
          state_nxt     = S_DRAIN;
        end else if (cnt == 16'd1) begin
          acc_start_nxt = 1'b1;
          state_nxt     = S_ACQ;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end

      S_ACQ: begin
        if (abort) begin
          acc_start_nxt = 1'b0;
          state_nxt     = S_DRAIN;
        end else if (acc_done) begin
          acc_start_nxt = 1'b0;
          m_valid_nxt   = 1'b1;
          m_tap_nxt     = phase_sel;
          m_count_nxt   = acc_data;
          m_last_nxt    = (phase_sel == last);
          low_seen_nxt  = 1'b0;
          taken_nxt     = 1'b0;
          state_nxt     = S_EMIT;
        end
      end

      // The beat is offered once; after the handshake m_valid drops while we
      // keep waiting for the accumulator to leave its done state.
      S_EMIT: begin
        low_seen_nxt   = seen_now;
        taken_nxt      = taken_now;
        abort_pend_nxt = pend_now;
        if (m_valid && m_ready) begin
          m_valid_nxt = 1'b0;
        end
        if (seen_now && taken_now) begin
          if (pend_now) begin
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end else if (phase_sel == last) begin
            sweep_done_nxt = 1'b1;
            state_nxt      = S_FINISH;
          end else begin
            phase_sel_nxt  = phase_sel + TAP_ONE;
            phase_load_nxt = 1'b1;
            cnt_nxt        = SETTLE_LD;
            state_nxt      = S_SETTLE;
          end
        end
      end

      S_FINISH: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end

      S_DRAIN: begin
        if (!acc_done) begin
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ets_sweep_ctrl.sv
// Scoreboard bench for ets_sweep_ctrl: directed sweeps with an accumulator
// model returning 100+tap; a monitor pops expected beats on each handshake.
module tb_ets_sweep_ctrl;

  localparam int TAP_W  = 8;
  localparam int SETTLE = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sweep_start = 1'b0;
  logic             abort = 1'b0;
  logic [TAP_W-1:0] last_tap = '0;
  logic [TAP_W-1:0] phase_sel;
  logic             phase_load;
  logic             acc_start;
  logic             acc_done = 1'b0;
  logic [31:0]      acc_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [TAP_W-1:0] m_tap;
  logic [31:0]      m_count;
  logic             m_last;
  logic             busy;
  logic             sweep_done;

  ets_sweep_ctrl #(.TAP_W(TAP_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .sweep_start(sweep_start), .abort(abort),
    .last_tap(last_tap), .phase_sel(phase_sel), .phase_load(phase_load),
    .acc_start(acc_start), .acc_done(acc_done), .acc_data(acc_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_tap(m_tap), .m_count(m_count),
    .m_last(m_last), .busy(busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAP_W-1:0] tap;
    logic [31:0]      cnt;
    logic             last;
  } beat_t;

  beat_t sb[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    pl_cyc = 0;
  int    sd_cnt = 0;
  int    acc_rise = 0;
  int    beats = 0;
  int    ready_mode = 0;
  int    extra_hold = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int t, input logic lst);
    beat_t b;
    b.tap  = TAP_W'(t);
    b.cnt  = 32'(100 + t);
    b.last = lst;
    sb.push_back(b);
  endtask

  // Pulse sweep_start and check the first post-start cycle.
  task automatic start_sweep(input int lt);
    @(posedge clk); #1;
    last_tap    = TAP_W'(lt);
    sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    @(negedge clk);
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_phase_load", 64'(phase_load), 64'd1);
    chk("start_phase_sel", 64'(phase_sel), 64'd0);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 3000);
    chk({nm, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  // Sink ready pattern and accumulator model, driven just after each edge.
  initial begin
    int rc;
    int lat;
    int hold;
    rc = 0; lat = 0; hold = 0;
    forever begin
      @(posedge clk); #1;
      rc++;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (rc % 3 == 0);
        default: m_ready = 1'b0;
      endcase
      if (!rst_n) begin
        acc_done = 1'b0; lat = 0; hold = 0;
      end else if (acc_start) begin
        if (!acc_done) begin
          if (lat == 2) begin
            acc_done = 1'b1;
            acc_data = 32'(100) + 32'(phase_sel);
          end else begin
            lat++;
          end
        end
        hold = extra_hold;
      end else begin
        lat = 0;
        if (acc_done) begin
          if (hold == 0) acc_done = 1'b0;
          else hold--;
        end
      end
    end
  end

  // Monitor: scoreboard pop on handshake, stall stability, settle gap, strobes.
  initial begin
    logic  prev_stall;
    logic  prev_acc;
    beat_t ps;
    beat_t e;
    prev_stall = 1'b0; prev_acc = 1'b0; ps = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_acc   = 1'b0;
      end else begin
        if (m_valid && m_ready) begin
          beats++;
          if (sb.size() == 0) begin
            chk("unexpected_beat_tap", 64'(m_tap), 64'hFFFF);
          end else begin
            e = sb.pop_front();
            chk("beat_tap", 64'(m_tap), 64'(e.tap));
            chk("beat_count", 64'(m_count), 64'(e.cnt));
            chk("beat_last", 64'(m_last), 64'(e.last));
          end
        end
        if (prev_stall) begin
          chk("stall_valid", 64'(m_valid), 64'd1);
          chk("stall_payload", 64'({m_tap, m_count, m_last}), 64'(ps));
        end
        prev_stall = m_valid && !m_ready;
        ps = {m_tap, m_count, m_last};
        if (phase_load) begin
          pl_cyc = cyc;
          chk("phase_load_acc_done_low", 64'(acc_done), 64'd0);
        end
        if (acc_start && !prev_acc) begin
          acc_rise++;
          chk("settle_gap", 64'(cyc - pl_cyc), 64'(SETTLE));
        end
        prev_acc = acc_start;
        if (sweep_done) begin
          sd_cnt++;
          chk("sweep_done_busy", 64'(busy), 64'd1);
        end
      end
    end
  end

  initial begin
    int sd0;
    int n;

    // Reset state
    #3;
    chk("rst_phase_sel", 64'(phase_sel), 64'd0);
    chk("rst_outputs", 64'({phase_load, acc_start, m_valid, m_last, busy, sweep_done}), 64'd0);
    chk("rst_m_tap", 64'(m_tap), 64'd0);
    chk("rst_m_count", 64'(m_count), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Normal sweep, sink always ready
    ready_mode = 0; extra_hold = 0; sd0 = sd_cnt; acc_rise = 0; beats = 0;
    for (int t = 0; t < 4; t++) push(t, t == 3);
    start_sweep(3);
    wait_idle("sweep1");
    chk("sweep1_done_cnt", 64'(sd_cnt - sd0), 64'd1);
    chk("sweep1_beats", 64'(beats), 64'd4);
    chk("sweep1_acc_rise", 64'(acc_rise), 64'd4);
    chk("sweep1_sb_empty", 64'(sb.size()), 64'd0);

    // Same sweep with sink ready one cycle in three
    ready_mode = 1; sd0 = sd_cnt; beats = 0;
    for (int t = 0; t < 4; t++) push(t, t == 3);
    start_sweep(3);
    wait_idle("sweep2");
    chk("sweep2_done_cnt", 64'(sd_cnt - sd0), 64'd1);
    chk("sweep2_beats", 64'(beats), 64'd4);
    chk("sweep2_sb_empty", 64'(sb.size()), 64'd0);

    // Accumulator holds done for 5 extra cycles after acc_start falls
    ready_mode = 0; extra_hold = 5; sd0 = sd_cnt; beats = 0;
    for (int t = 0; t < 3; t++) push(t, t == 2);
    start_sweep(2);
    wait_idle("sweep3");
    chk("sweep3_done_cnt", 64'(sd_cnt - sd0), 64'd1);
    chk("sweep3_beats", 64'(beats), 64'd3);
    chk("sweep3_sb_empty", 64'(sb.size()), 64'd0);
    extra_hold = 0;

    // Abort during settle of tap 2
    ready_mode = 0; sd0 = sd_cnt; acc_rise = 0; beats = 0;
    push(0, 1'b0); push(1, 1'b0);
    start_sweep(3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(phase_load && phase_sel == TAP_W'(2)) && n < 2000);
    chk("abort1_reach_tap2", 64'(phase_sel), 64'd2);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_idle("abort1");
    repeat (3) @(negedge clk);
    chk("abort1_acc_start_low", 64'(acc_start), 64'd0);
    chk("abort1_acc_rise", 64'(acc_rise), 64'd2);
    chk("abort1_no_done", 64'(sd_cnt - sd0), 64'd0);
    chk("abort1_beats", 64'(beats), 64'd2);
    chk("abort1_sb_empty", 64'(sb.size()), 64'd0);

    // Fresh sweep after abort starts from tap 0
    sd0 = sd_cnt; beats = 0;
    push(0, 1'b0); push(1, 1'b1);
    start_sweep(1);
    wait_idle("resweep");
    chk("resweep_done_cnt", 64'(sd_cnt - sd0), 64'd1);
    chk("resweep_beats", 64'(beats), 64'd2);

    // Abort while the tap-0 beat is stalled
    ready_mode = 2; sd0 = sd_cnt; beats = 0;
    push(0, 1'b0);
    start_sweep(3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_valid && n < 2000);
    chk("abort2_valid_seen", 64'(m_valid), 64'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort2_valid_held", 64'(m_valid), 64'd1);
    chk("abort2_payload", 64'({m_tap, m_count, m_last}), 64'({8'd0, 32'd100, 1'b0}));
    chk("abort2_no_load", 64'(phase_load), 64'd0);
    ready_mode = 0;
    wait_idle("abort2");
    repeat (2) @(negedge clk);
    chk("abort2_no_done", 64'(sd_cnt - sd0), 64'd0);
    chk("abort2_beats", 64'(beats), 64'd1);
    chk("abort2_valid_low", 64'(m_valid), 64'd0);
    chk("abort2_sb_empty", 64'(sb.size()), 64'd0);

    // Reset while acquiring tap 1
    ready_mode = 0; beats = 0;
    push(0, 1'b0);
    start_sweep(3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(acc_start && phase_sel == TAP_W'(1)) && n < 2000);
    chk("rst_acq_tap1", 64'(phase_sel), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_phase_sel", 64'(phase_sel), 64'd0);
    chk("midrst_outputs", 64'({phase_load, acc_start, m_valid, m_last, busy, sweep_done}), 64'd0);
    chk("midrst_m_tap", 64'(m_tap), 64'd0);
    chk("midrst_m_count", 64'(m_count), 64'd0);
    chk("midrst_sb_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    sd0 = sd_cnt; beats = 0;
    push(0, 1'b0); push(1, 1'b1);
    start_sweep(1);
    wait_idle("postrst");
    chk("postrst_done_cnt", 64'(sd_cnt - sd0), 64'd1);
    chk("postrst_beats", 64'(beats), 64'd2);
    chk("postrst_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
